// File: rtl/dead_time_generator.sv
// Multi-phase dead-time generator: each phase turns a PWM command into
// complementary hs/ls gate drives separated by a programmable dead time.

module dtg_lane #(
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           force_off,
  input  logic           start_ok,
  input  logic           pwm,
  input  logic [DTW-1:0] dt_cfg,
  output logic           hs,
  output logic           ls
);
  typedef enum logic [2:0] {OFF, DT_R, HS_ON, DT_F, LS_ON} state_t;

  state_t         state, state_nxt;
  logic [DTW-1:0] cnt, cnt_nxt, dt_load;

  // Counter holds remaining cycles minus one, so dt_cfg of 0 or 1 both give one cycle.
  assign dt_load = (dt_cfg == '0) ? '0 : dt_cfg - DTW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (force_off) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF:   if (start_ok) begin state_nxt = DT_F; cnt_nxt = dt_load; end
        LS_ON: if (pwm)      begin state_nxt = DT_R; cnt_nxt = dt_load; end
        HS_ON: if (!pwm)     begin state_nxt = DT_F; cnt_nxt = dt_load; end
        DT_R, DT_F: begin
          if (cnt == '0) state_nxt = pwm ? HS_ON : LS_ON;
          else           cnt_nxt   = cnt - DTW'(1);
        end
        default: begin state_nxt = OFF; cnt_nxt = '0; end
      endcase
    end
  end

  // Gate drives are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      hs    <= 1'b0;
      ls    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hs    <= (state_nxt == HS_ON);
      ls    <= (state_nxt == LS_ON);
    end
  end
endmodule

module dead_time_generator #(
  parameter int NPHASES = 4,
  parameter int DTW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NPHASES-1:0] pwm_ph,
  input  logic [DTW-1:0]     dt_cfg,
  input  logic               fault,
  input  logic               fault_clr,
  output logic [NPHASES-1:0] hs,
  output logic [NPHASES-1:0] ls,
  output logic               fault_active
);
  logic force_off, start_ok;

  assign force_off = fault | ~en;
  // Latched fault holds channels in OFF until cleared; restart then goes via DT_F.
  assign start_ok  = ~fault_active;

  always_ff @(posedge clk) begin
    if (rst)            fault_active <= 1'b0;
    else if (fault)     fault_active <= 1'b1;
    else if (fault_clr) fault_active <= 1'b0;
  end

  dtg_lane #(.DTW(DTW)) u_lane [NPHASES-1:0] (
    .clk      (clk),
    .rst      (rst),
    .force_off(force_off),
    .start_ok (start_ok),
    .pwm      (pwm_ph),
    .dt_cfg   (dt_cfg),
    .hs       (hs),
    .ls       (ls)
  );
endmodule

// File: tb/tb_dead_time_generator.sv
// Scoreboard bench for dead_time_generator: directed vectors with cycle-stamped
// expectations plus a randomized run under continuous overlap/gap monitoring.

module tb_dead_time_generator;
  localparam int NP  = 4;
  localparam int DTW = 8;

  logic          clk = 1'b0;
  logic          rst, en, fault, fault_clr;
  logic [NP-1:0] pwm_ph, hs, ls;
  logic [DTW-1:0] dt_cfg;
  logic          fault_active;

  dead_time_generator #(.NPHASES(NP), .DTW(DTW)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_ph(pwm_ph), .dt_cfg(dt_cfg),
    .fault(fault), .fault_clr(fault_clr), .hs(hs), .ls(ls),
    .fault_active(fault_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NP-1:0] hs;
    logic [NP-1:0] ls;
    logic          fa;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;

  // Per-phase gap tracking
  logic prev_g [NP];
  bit   seen_drop [NP];
  int   off_start [NP];
  int   min_n [NP];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs after edge E are observed at the negedge where cyc == E.
  always @(negedge clk) begin
    exp_t x;
    int   n_now;
    logic g;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      n_tot++;
      if (x.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", x.name, x.cyc, cyc);
      else if (hs !== x.hs || ls !== x.ls || fault_active !== x.fa)
        $display("FAIL %s @%0d: got hs=%b ls=%b fa=%b, want hs=%b ls=%b fa=%b",
                 x.name, cyc, hs, ls, fault_active, x.hs, x.ls, x.fa);
      else n_pass++;
    end
    n_tot++;
    if ((hs & ls) !== '0) $display("FAIL overlap @%0d: hs=%b ls=%b", cyc, hs, ls);
    else n_pass++;
    n_now = (dt_cfg == '0) ? 1 : int'(dt_cfg);
    for (int k = 0; k < NP; k++) begin
      g = hs[k] | ls[k];
      if (prev_g[k] && !g) begin
        seen_drop[k] = 1'b1;
        off_start[k] = cyc;
        min_n[k]     = n_now;
      end else if (!g) begin
        if (n_now < min_n[k]) min_n[k] = n_now;
      end else if (!prev_g[k] && seen_drop[k]) begin
        n_tot++;
        if (cyc - off_start[k] < min_n[k])
          $display("FAIL gap ph%0d @%0d: got %0d cycles, want >= %0d",
                   k, cyc, cyc - off_start[k], min_n[k]);
        else n_pass++;
      end
      prev_g[k] = g;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_at(input int c, input logic [NP-1:0] h, input logic [NP-1:0] l,
                        input logic f, input string nm);
    exp_t x;
    x.cyc = c; x.hs = h; x.ls = l; x.fa = f; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    int e;
    for (int k = 0; k < NP; k++) begin
      prev_g[k] = 1'b0; seen_drop[k] = 1'b0; off_start[k] = 0; min_n[k] = 1;
    end
    rst = 1'b1; en = 1'b0; fault = 1'b0; fault_clr = 1'b0; pwm_ph = '0; dt_cfg = '0;
    repeat (2) step();
    exp_at(cyc + 1, 4'b0000, 4'b0000, 1'b0, "reset");
    step();

    // Start-up through a full DT_F
    rst = 1'b0; en = 1'b1; pwm_ph = 4'b0000; dt_cfg = 8'd5; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b0000, 1'b0, "start_dt");
    exp_at(e + 4, 4'b0000, 4'b0000, 1'b0, "start_dt_end");
    exp_at(e + 5, 4'b0000, 4'b1111, 1'b0, "start_ls_on");
    repeat (8) step();

    // Normal switching on phase 1
    pwm_ph = 4'b0010; dt_cfg = 8'd3; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b1101, 1'b0, "rise_ls_off");
    exp_at(e + 2, 4'b0000, 4'b1101, 1'b0, "rise_dt_end");
    exp_at(e + 3, 4'b0010, 4'b1101, 1'b0, "rise_hs_on");
    repeat (20) step();
    pwm_ph = 4'b0000; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b1101, 1'b0, "fall_hs_off");
    exp_at(e + 2, 4'b0000, 4'b1101, 1'b0, "fall_dt_end");
    exp_at(e + 3, 4'b0000, 4'b1111, 1'b0, "fall_ls_on");
    repeat (5) step();

    // Short pulse swallowed by a 4-cycle dead time
    pwm_ph = 4'b0001; dt_cfg = 8'd4; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b1110, 1'b0, "short_ls_off");
    exp_at(e + 1, 4'b0000, 4'b1110, 1'b0, "short_hs_low");
    exp_at(e + 3, 4'b0000, 4'b1110, 1'b0, "short_dt_end");
    exp_at(e + 4, 4'b0000, 4'b1111, 1'b0, "short_ls_back");
    repeat (2) step();
    pwm_ph = 4'b0000;
    repeat (4) step();

    // dt_cfg=0 behaves as one cycle
    pwm_ph = 4'b0001; dt_cfg = 8'd0; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b1110, 1'b0, "dt0_gap");
    exp_at(e + 1, 4'b0001, 4'b1110, 1'b0, "dt0_hs_on");
    repeat (3) step();

    // Fault while phase 0 conducts high side
    dt_cfg = 8'd2; fault = 1'b1; e = cyc + 1;
    exp_at(e, 4'b0000, 4'b0000, 1'b1, "fault_off");
    step();
    fault = 1'b0;
    step();
    fault = 1'b1; fault_clr = 1'b1; e = cyc + 1;
    exp_at(e, 4'b0000, 4'b0000, 1'b1, "fault_wins");
    step();
    fault = 1'b0; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b0000, 1'b0, "fault_clr");
    exp_at(e + 1, 4'b0000, 4'b0000, 1'b0, "refault_dtf");
    exp_at(e + 2, 4'b0000, 4'b0000, 1'b0, "refault_dt_end");
    exp_at(e + 3, 4'b0001, 4'b1110, 1'b0, "fault_resume");
    step();
    fault_clr = 1'b0;
    repeat (4) step();

    // Reset in the middle of a long DT_R, then restart with a new dead time
    dt_cfg = 8'd200; pwm_ph = 4'b0011; e = cyc + 1;
    exp_at(e,     4'b0001, 4'b1100, 1'b0, "dtr_enter");
    exp_at(e + 9, 4'b0001, 4'b1100, 1'b0, "dtr_hold");
    repeat (10) step();
    rst = 1'b1; e = cyc + 1;
    exp_at(e, 4'b0000, 4'b0000, 1'b0, "rst_mid");
    step();
    rst = 1'b0; dt_cfg = 8'd3; e = cyc + 1;
    exp_at(e,     4'b0000, 4'b0000, 1'b0, "rst_dtf");
    exp_at(e + 2, 4'b0000, 4'b0000, 1'b0, "rst_dt_end");
    exp_at(e + 3, 4'b0011, 4'b1100, 1'b0, "rst_resume");
    repeat (5) step();

    // en=0 forces OFF at the sampling edge
    en = 1'b0; e = cyc + 1;
    exp_at(e, 4'b0000, 4'b0000, 1'b0, "en_off");
    step();
    en = 1'b1;
    repeat (3) step();

    // Random run: overlap and gap checked by the monitor every cycle
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < NP; b++)
        if ($urandom_range(0, 9) == 0) pwm_ph[b] = ~pwm_ph[b];
      en        = ($urandom_range(0, 199) != 0);
      fault     = ($urandom_range(0, 299) == 0);
      fault_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) dt_cfg = DTW'($urandom_range(0, 6));
      step();
    end
    repeat (3) step();

    n_tot++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/dead_time_generator.md
DEAD_TIME_GENERATOR -- requirements
Module: dead_time_generator

Interface
REQ-001 The block SHALL have parameter NPHASES, default 4, giving the number of phase channels.
REQ-002 The block SHALL have parameter DTW, default 8, giving the width of the dead-time configuration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: global enable, where 0 forces all channels OFF.
REQ-006 The block SHALL have port pwm_ph, input, NPHASES bits: per-phase PWM command from the phase-shifter stage.
REQ-007 The block SHALL have port dt_cfg, input, DTW bits: dead time in clk cycles.
REQ-008 The block SHALL have port fault, input, 1 bit: synchronous fault request.
REQ-009 The block SHALL have port fault_clr, input, 1 bit: clear for the latched fault.
REQ-010 The block SHALL have port hs, output, NPHASES bits: high-side gate drive per phase.
REQ-011 The block SHALL have port ls, output, NPHASES bits: low-side gate drive per phase.
REQ-012 The block SHALL have port fault_active, output, 1 bit: latched fault status.

Function
REQ-013 Each phase SHALL run an independent FSM with states OFF, DT_R, HS_ON, DT_F and LS_ON, plus its own DTW-bit down-counter.
REQ-014 Each FSM SHALL drive its outputs per state: OFF, DT_R and DT_F give hs=0, ls=0; HS_ON gives hs=1, ls=0; LS_ON gives hs=0, ls=1.
REQ-015 hs and ls SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-016 hs[k] and ls[k] SHALL never both be 1 in any cycle, under any input sequence.
REQ-017 Every dead-time interval SHALL last N = max(dt_cfg, 1) cycles, with dt_cfg sampled on the cycle the interval is entered; later dt_cfg changes SHALL NOT affect a running interval.
REQ-018 OFF SHALL go to DT_F when en=1 and fault_active=0, and SHALL stay in OFF otherwise.
REQ-019 LS_ON SHALL go to DT_R when pwm_ph[k]=1.
REQ-020 HS_ON SHALL go to DT_F when pwm_ph[k]=0.
REQ-021 When its count expires, DT_R SHALL go to HS_ON if pwm_ph[k]=1 and to LS_ON if pwm_ph[k]=0.
REQ-022 When its count expires, DT_F SHALL go to LS_ON if pwm_ph[k]=0 and to HS_ON if pwm_ph[k]=1.
REQ-023 Latency, rise: if pwm_ph[k] is first sampled 1 at edge e while in LS_ON, ls[k] SHALL be 0 from edge e, and hs[k] SHALL be 1 from edge e+N provided pwm_ph[k] stays 1.
REQ-024 Latency, fall: the same timing as REQ-023 SHALL apply with hs and ls swapped.
REQ-025 A PWM pulse shorter than N cycles SHALL never reach its gate; that side stays 0 for the whole pulse.
REQ-026 en=0 sampled at any edge SHALL force every channel to OFF at that edge.
REQ-027 fault=1 sampled at any edge SHALL set fault_active and force every channel to OFF at that edge.
REQ-028 fault_active SHALL clear only on fault_clr=1 with fault=0; when fault and fault_clr are both 1, fault SHALL win.
REQ-029 Priority SHALL be: rst, then fault, then en=0, then normal FSM transitions.
REQ-030 After fault_active clears, with en=1, channels SHALL re-enter through DT_F, so a full dead time precedes any gate turn-on.

Reset
REQ-031 rst=1 at an edge SHALL set all FSMs to OFF, all counters to 0, hs=0, ls=0 and fault_active=0, including mid-interval.
REQ-032 The first turn-on after reset SHALL be preceded by a full DT_F interval.

Verification
REQ-033 Bench SHALL check start-up: dt_cfg=5, en rises, pwm_ph=0 -> all ls=1 exactly 5 cycles after the first edge with en=1; hs stays 0.
REQ-034 Bench SHALL check normal switching: dt_cfg=3, pwm_ph[1] high for 20 cycles -> ls[1] falls at the sampling edge, hs[1] rises 3 cycles later, hs[1] falls at the falling sample, ls[1] rises 3 cycles later.
REQ-035 Bench SHALL check short pulses: dt_cfg=4, 2-cycle pwm pulse -> hs stays 0 and ls returns to 1 at edge e+4; dt_cfg=0 -> 1-cycle dead time.
REQ-036 Bench SHALL check fault: fault pulse while in HS_ON -> hs=ls=0 next edge; fault and fault_clr together -> fault_active stays 1; fault_clr alone -> fault_active=0, then DT_F before conduction resumes.
REQ-037 Bench SHALL check reset mid-interval: rst during DT_R with dt_cfg=200 -> outputs 0; rerun with a fresh interval using the new dt_cfg.
REQ-038 Bench SHALL run 10k random cycles (pwm_ph, en, fault, dt_cfg) while asserting hs&ls==0 every cycle and a minimum hs/ls gap of N cycles per phase.
